dmem_responder: RTL

//  Responder (target) end of the CPU data-memory request interface: accepts one

---
 rtl/dmem_responder_pkg.sv | 12 +
 rtl/dmem_responder_array.sv | 24 ++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset.
import dmem_responder_pkg::*;

module dmem_responder_array #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: request/response handshake around a word RAM.
// Define DMEM_ERR_EN to flag out-of-range/misaligned accesses on rsp_err.
import dmem_responder_pkg::*;

module dmem_responder #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned CNT_W = 4;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic                  lat_write;
   logic [WORD_W-1:0]     lat_addr;
   logic [WORD_W-1:0]     lat_wdata;

   logic                  acc_c;
   logic                  acc_write_c;
   logic [WORD_W-1:0]     acc_addr_c;
   logic [WORD_W-1:0]     acc_wdata_c;
   logic [WORD_W-1:0]     offset_c;
   logic                  in_range_c;
   logic                  ok_c;
   logic                  err_c;
   logic                  we_c;
   logic [DEPTH_LOG2-1:0] idx_c;
   logic [WORD_W-1:0]     mem_rdata;
   logic [WORD_W-1:0]     acc_rdata_c;

   assign req_ready = (state == ST_IDLE) && !rst;

   // Zero-wait builds access straight from the request; otherwise from the latch.
   always_comb begin
      acc_c       = 1'b0;
      acc_write_c = lat_write;
      acc_addr_c  = lat_addr;
      acc_wdata_c = lat_wdata;
      case (state)
         ST_IDLE: begin
            if (WAIT_CYCLES == 0) begin
               acc_c       = req_valid;
               acc_write_c = req_write;
               acc_addr_c  = req_addr;
               acc_wdata_c = req_wdata;
            end
         end
         ST_BUSY: acc_c = (cnt == CNT_W'(0));
         default: acc_c = 1'b0;
      endcase
   end

   always_comb begin
      offset_c   = acc_addr_c - BASE_ADDR;
      in_range_c = (acc_addr_c >= BASE_ADDR) &&
                   ((offset_c >> (DEPTH_LOG2 + 2)) == WORD_W'(0));
      idx_c      = offset_c[DEPTH_LOG2+1:2];
`ifdef DMEM_ERR_EN
      ok_c       = in_range_c && (acc_addr_c[1:0] == 2'b00);
      err_c      = !ok_c;
`else
      ok_c       = in_range_c;
      err_c      = 1'b0;
`endif
      we_c        = acc_c && acc_write_c && ok_c && !rst;
      acc_rdata_c = (ok_c && !acc_write_c) ? mem_rdata : WORD_W'(0);
   end

   dmem_responder_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .we    (we_c),
      .idx   (idx_c),
      .wdata (acc_wdata_c),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= acc_rdata_c;
                     rsp_err   <= err_c;
                  end else begin
                     state <= ST_BUSY;
                     cnt   <= CNT_W'(WAIT_CYCLES - 1);
                  end
               end
            end
            ST_BUSY: begin
               if (acc_c) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= acc_rdata_c;
                  rsp_err   <= err_c;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
